// File: rtl/register_demultiplexer_if.sv
// register_demultiplexer_if
//   Bundles the producer handshake and the per-lane consumer handshake of
//   register_demultiplexer.
//   Signals:
//     inData    word offered by the producer
//     select    destination lane index
//     inValid   producer offers inData/select
//     inReady   demux accepts this cycle
//     outputBus packed lane registers, lane i at [i*inputWidth +: inputWidth]
//     outValid  per-lane "holds an unconsumed word"
//     outReady  per-lane consumer acknowledge
//     dropCount saturating count of accepted out-of-range words
//   Modports: master = producer/consumer side, slave = demux side.
interface register_demultiplexer_if #(
  parameter int inputWidth  = 8,
  parameter int numOutputs  = 4,
  parameter int selectLines = 2
);
  logic [inputWidth-1:0]            inData;
  logic [selectLines-1:0]           select;
  logic                             inValid;
  logic                             inReady;
  logic [inputWidth*numOutputs-1:0] outputBus;
  logic [numOutputs-1:0]            outValid;
  logic [numOutputs-1:0]            outReady;
  logic [7:0]                       dropCount;

  modport master (
    output inData, select, inValid, outReady,
    input  inReady, outputBus, outValid, dropCount
  );

  modport slave (
    input  inData, select, inValid, outReady,
    output inReady, outputBus, outValid, dropCount
  );
endinterface

// File: rtl/register_demultiplexer.sv
// register_demultiplexer
//   Registered 1-to-N demultiplexer. A word accepted with a lane select is
//   captured into that lane's one-word holding register and held until the
//   lane's consumer acknowledges it. Out-of-range selects are accepted and
//   discarded, counted by a saturating 8-bit drop counter.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    register_demultiplexer_if.slave (producer + lane handshakes)
//   Configuration macro:
//     REGISTER_DEMUX_FILL_ON_DRAIN_EN - when defined, a full lane being
//     drained may be refilled at the same edge (inReady also looks at
//     outReady of the selected lane).
module register_demultiplexer #(
  parameter int inputWidth  = 8,
  parameter int numOutputs  = 4,
  parameter int selectLines = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  register_demultiplexer_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  lane_state_e           state_p0  [numOutputs];
  lane_state_e           state_nxt [numOutputs];
  logic [inputWidth-1:0] data_p0   [numOutputs];
  logic [7:0]            drop_p0;

  logic [numOutputs-1:0] vld_p0;
  logic [numOutputs-1:0] sel_hit;
  logic [numOutputs-1:0] lane_free;
  logic [numOutputs-1:0] load;
  logic [numOutputs-1:0] drain;
  logic                  sel_in_range;
  logic                  in_ready;
  logic                  in_xfer;
  logic [inputWidth*numOutputs-1:0] out_bus;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lane decode is done per lane so an out-of-range select never indexes
  // past the lane arrays; "no lane hit" is exactly the out-of-range case.
  always_comb begin
    sel_hit = '0;
    vld_p0  = '0;
    for (int i = 0; i < numOutputs; i++) begin
      sel_hit[i] = (bus.select == selectLines'(i));
      vld_p0[i]  = (state_p0[i] == FULL);
    end
  end

  assign sel_in_range = |sel_hit;

`ifdef REGISTER_DEMUX_FILL_ON_DRAIN_EN
  assign lane_free = ~vld_p0 | bus.outReady;
`else
  assign lane_free = ~vld_p0;
`endif

  // Out-of-range words are always accepted so the producer never stalls on them.
  assign in_ready = !sel_in_range || |(sel_hit & lane_free);
  assign in_xfer  = bus.inValid && in_ready;
  assign load     = in_xfer ? sel_hit : '0;
  assign drain    = vld_p0 & bus.outReady;

  // Lane next-state: a refill wins over a drain in the same cycle.
  always_comb begin
    for (int i = 0; i < numOutputs; i++) begin
      state_nxt[i] = state_p0[i];
      if (load[i]) begin
        state_nxt[i] = FULL;
      end else if (drain[i]) begin
        state_nxt[i] = EMPTY;
      end
    end
  end

  // ---- stage p0: lane state, lane data and drop counter registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < numOutputs; i++) begin
        state_p0[i] <= EMPTY;
      end
    end else begin
      for (int i = 0; i < numOutputs; i++) begin
        state_p0[i] <= state_nxt[i];
      end
    end
  end

  // Data keeps its last word after a drain; only a load changes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < numOutputs; i++) begin
        data_p0[i] <= '0;
      end
    end else begin
      for (int i = 0; i < numOutputs; i++) begin
        if (load[i]) begin
          data_p0[i] <= bus.inData;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_p0 <= '0;
    end else if (in_xfer && !sel_in_range) begin
      drop_p0 <= sat_inc(drop_p0);
    end
  end

  always_comb begin
    out_bus = '0;
    for (int i = 0; i < numOutputs; i++) begin
      out_bus[i*inputWidth +: inputWidth] = data_p0[i];
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.outValid  = vld_p0;
  assign bus.outputBus = out_bus;
  assign bus.dropCount = drop_p0;

endmodule

// File: tb/tb_register_demultiplexer.sv
// tb_register_demultiplexer
//   Randomized and directed stimulus for register_demultiplexer
//   (inputWidth=8, numOutputs=3, selectLines=2; select=3 is out of range),
//   checked against a lane-array reference model kept in the bench.
//   Honours REGISTER_DEMUX_FILL_ON_DRAIN_EN when compiled with it.
module tb_register_demultiplexer;

  logic clk;
  logic reset;

  register_demultiplexer_if #(
    .inputWidth(8), .numOutputs(3), .selectLines(2)
  ) bus_if ();

  register_demultiplexer #(
    .inputWidth(8), .numOutputs(3), .selectLines(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

`ifdef REGISTER_DEMUX_FILL_ON_DRAIN_EN
  localparam bit FOD = 1'b1;
`else
  localparam bit FOD = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: what each lane holds and whether it is full.
  bit         m_full [3];
  logic [7:0] m_data [3];
  int         m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic exp_ready();
    int s;
    s = int'(bus_if.select);
    if (s >= 3) return 1'b1;
    return !m_full[s] || (FOD && bus_if.outReady[s]);
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = 8'h00;
    end
    m_drop = 0;
  end

  // Model update on each rising edge from the inputs held across it.
  always @(posedge clk) begin : model_upd
    bit acc;
    int s;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = 8'h00;
      end
      m_drop = 0;
    end else begin
      acc = bus_if.inValid && exp_ready();
      s   = int'(bus_if.select);
      for (int i = 0; i < 3; i++)
        if (m_full[i] && bus_if.outReady[i]) m_full[i] = 1'b0;
      if (acc) begin
        if (s < 3) begin
          m_full[s] = 1'b1;
          m_data[s] = bus_if.inData;
        end else if (m_drop < 255) begin
          m_drop = m_drop + 1;
        end
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready",   32'(bus_if.inReady),   32'(exp_ready()));
      check("out_valid",  32'(bus_if.outValid),  32'({m_full[2], m_full[1], m_full[0]}));
      check("output_bus", 32'(bus_if.outputBus), 32'({m_data[2], m_data[1], m_data[0]}));
      check("drop_count", 32'(bus_if.dropCount), 32'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [7:0] d, input logic v,
                       input logic [2:0] ordy);
    bus_if.select   = sel;
    bus_if.inData   = d;
    bus_if.inValid  = v;
    bus_if.outReady = ordy;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'd0, 8'h00, 1'b0, 3'b000);
    step();
    step();
    reset = 1'b0;

    // Basic routing to lane 2.
    drive(2'd2, 8'hA5, 1'b1, 3'b000);
    step();
    check("route_valid", 32'(bus_if.outValid), 32'h4);
    check("route_data",  32'(bus_if.outputBus[23:16]), 32'hA5);
    drive(2'd2, 8'h5A, 1'b1, 3'b000);
    #1;
    check("full_lane_blocks", 32'(bus_if.inReady), 32'h0);
    drive(2'd2, 8'h5A, 1'b0, 3'b100);
    step();
    check("drain_valid", 32'(bus_if.outValid), 32'h0);
    check("drain_keeps_data", 32'(bus_if.outputBus[23:16]), 32'hA5);

    // Independent lanes: drain lane 0 while filling lane 1.
    drive(2'd0, 8'h11, 1'b1, 3'b000);
    step();
    drive(2'd1, 8'h22, 1'b1, 3'b001);
    step();
    check("indep_valid", 32'(bus_if.outValid), 32'h2);
    check("indep_lane1", 32'(bus_if.outputBus[15:8]), 32'h22);
    check("indep_lane0", 32'(bus_if.outputBus[7:0]), 32'h11);
    drive(2'd0, 8'h00, 1'b0, 3'b010);
    step();

    // Out-of-range flood saturates the drop counter.
    for (int n = 0; n < 300; n++) begin
      drive(2'd3, 8'($urandom), 1'b1, 3'b000);
      #1;
      check("oor_ready", 32'(bus_if.inReady), 32'h1);
      step();
    end
    check("oor_drop_sat", 32'(bus_if.dropCount), 32'd255);
    check("oor_lanes",    32'(bus_if.outputBus), 32'hA52211);
    check("oor_valid",    32'(bus_if.outValid),  32'h0);

    // Drain/refill of a full lane.
    drive(2'd0, 8'h01, 1'b1, 3'b000);
    step();
    drive(2'd0, 8'h02, 1'b1, 3'b001);
    #1;
    if (FOD) begin
      check("refill_ready", 32'(bus_if.inReady), 32'h1);
      step();
      check("refill_valid", 32'(bus_if.outValid[0]), 32'h1);
      check("refill_data",  32'(bus_if.outputBus[7:0]), 32'h02);
    end else begin
      check("refill_blocked", 32'(bus_if.inReady), 32'h0);
      step();
      check("refill_gap_valid", 32'(bus_if.outValid[0]), 32'h0);
      check("refill_gap_data",  32'(bus_if.outputBus[7:0]), 32'h01);
      check("refill_ready2",    32'(bus_if.inReady), 32'h1);
      step();
      check("refill_valid", 32'(bus_if.outValid[0]), 32'h1);
      check("refill_data",  32'(bus_if.outputBus[7:0]), 32'h02);
    end
    drive(2'd0, 8'h00, 1'b0, 3'b000);
    step();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)));
      step();
    end

    // Asynchronous reset mid-cycle with lane 1 full.
    drive(2'd1, 8'h77, 1'b1, 3'b000);
    step();
    drive(2'd1, 8'h00, 1'b0, 3'b000);
    check("pre_reset_lane1", 32'(bus_if.outValid[1]), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(bus_if.outValid),  32'h0);
    check("rst_bus",   32'(bus_if.outputBus), 32'h0);
    check("rst_drop",  32'(bus_if.dropCount), 32'h0);
    for (int s = 0; s < 4; s++) begin
      bus_if.select = 2'(s);
      #1;
      check("rst_ready", 32'(bus_if.inReady), 32'h1);
    end
    step();
    reset = 1'b0;

    // More random traffic after reset.
    for (int n = 0; n < 500; n++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)));
      step();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/register_demultiplexer.md
# register_demultiplexer

Registered, parameterized 1-to-N demultiplexer with a valid/ready handshake on the input and on each output lane. Each lane has a one-word holding register. A word presented with a lane select is captured into that lane's register and held until the lane's consumer acknowledges it. This is the write-side counterpart of the datapath's packed-bus N-to-1 selector. It fans one producer (ALU result, bus read data) out to N independently draining consumers, and its output bus uses the same packed lane layout the selector consumes.

## Interface
- `inputWidth`, default 8: data word width in bits.
- `numOutputs`, default 4: number of output lanes. Legal range is 2..2^selectLines.
- `selectLines`, default 2: width of `select`.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `inData`  in  inputWidth: word to route.
- `select`  in  selectLines: destination lane index.
- `inValid`  in  1: the producer offers `inData`/`select` this cycle.
- `inReady`  out  1: the block accepts this cycle.
- `outputBus`  out  inputWidth*numOutputs: packed lane registers. Lane i occupies `[i*inputWidth +: inputWidth]`.
- `outValid`  out  numOutputs: bit i is set while lane i holds an unconsumed word.
- `outReady`  in  numOutputs: consumer i takes lane i's word this cycle.
- `dropCount`  out  8: saturating count of accepted words whose select was out of range.

## Operation
- **Transfers.**
  - Input transfer: `inValid && inReady` at a rising edge.
  - Lane i transfer: `outValid[i] && outReady[i]` at a rising edge.
- **Lane states.** Each lane is a 2-state machine, EMPTY (outValid=0) or FULL (outValid=1).
  - EMPTY→FULL on an input transfer with `select==i`.
  - FULL→EMPTY on a lane i transfer with no simultaneous refill.
  - FULL→FULL on a simultaneous drain and refill; this is possible only with the configuration macro enabled.
- **inReady.**
  - In-range select (`select < numOutputs`): inReady = !outValid[select], plus the macro term below.
  - Out-of-range select: inReady = 1.
  - inReady depends only on `select` and lane state, never on `inValid`.
- **Out-of-range accept.**
  - The word is discarded; no lane changes.
  - `dropCount` increments and saturates at 255, holding there until reset.
- **Data retention.**
  - Lane data registers load only on an input transfer to that lane.
  - After a drain, `outputBus` keeps the last word; only `outValid` clears.
- **Independence.** Lanes drain independently. Any number of lanes may transfer in the same cycle as an input transfer to a different lane.
- **Width rules.** Output width is exactly inputWidth*numOutputs. When numOutputs < 2^selectLines, the unused select codes are the out-of-range codes.

## Timing
- **Reset values.** While `reset` is high, regardless of clock:
  - `outputBus` = 0.
  - `outValid` = 0.
  - `dropCount` = 0.
  - `inReady` is then combinationally 1 for any select.
- **Reset mid-operation.** Pending lane words are lost. No partial transfer completes on the edge where reset deasserts; the first transfer can occur on the following edge.
- **Latency.** An input transfer at edge k gives `outValid[select]`=1 and the new data on `outputBus` after edge k. Lane i can transfer at edge k+1 at the earliest.
- **Drain.** A lane transfer at edge k clears `outValid[i]` after edge k, unless the lane is refilled at edge k.
- **Throughput.** A single lane sustains one word every 2 cycles without the macro and one word per cycle with it. Alternating lanes sustains one word per cycle in either build.
- **Combinational paths.** `inReady` depends combinationally on `select`. With the macro enabled it also depends on `outReady`. There is no combinational path from `inData` to any output.

## Configuration
- Macro: `REGISTER_DEMUX_FILL_ON_DRAIN_EN`.
- **Defined:** for an in-range select, inReady = !outValid[select] || outReady[select]. A full lane being drained at edge k may be refilled at the same edge; its outValid stays 1 and its data updates to the new word.
- **Undefined:** for an in-range select, inReady = !outValid[select]. A full lane must go EMPTY for at least one edge before refill. There is no outReady→inReady path.

## Test plan
Bench parameters: inputWidth=8, numOutputs=3, selectLines=2, so select=3 is out of range.
- **Reset.** Assert `reset` asynchronously mid-cycle with lane 1 full → `outValid`=3'b000, `outputBus`=24'h000000 and `dropCount`=0 immediately; inReady=1.
- **Basic routing.** Send 8'hA5 to select=2 with outReady=0 → after 1 edge, outValid=3'b100 and bits[23:16]=8'hA5. A second offer to select=2 sees inReady=0. Raise outReady[2] → outValid=3'b000 and bits[23:16] still 8'hA5.
- **Independent lanes.** Lane 0 holds 8'h11. Send 8'h22 to lane 1 in the same cycle outReady[0]=1 → outValid=3'b010, bits[15:8]=8'h22, bits[7:0]=8'h11.
- **Out-of-range.** Send 300 words with select=3 → inReady=1 every cycle, lanes unchanged, dropCount=255 (saturated).
- **Drain/refill, macro undefined.** Lane 0 holds 8'h01 with outReady[0]=1; offer 8'h02 to select=0 → first cycle inReady=0; 8'h02 is accepted one edge later.
- **Drain/refill, macro defined.** Same stimulus → inReady=1, outValid[0] stays 1 and bits[7:0]=8'h02 after a single edge.
